// File: rtl/lifo_pop_streamer.sv
// lifo_pop_streamer: drains words from a LIFO stack using spaced single-cycle
// Read pulses and streams them out through a 2-entry valid/ready buffer.
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-low reset
//   Drain_Start/Len      drain request; Drain_Len=0 drains until LIFO_Empty
//   LIFO_Empty/Data      flag and registered Data_out of the LIFO
//   Read                 pop pulse to the LIFO
//   Out_Valid/Ready/Data/Last  output stream (Last marks final word of a
//                        length-terminated drain)
//   Busy, Done, Drain_Short    drain status; Drain_Short is qualified by Done
//   Pop_Total            Read pulse count since reset (LIFO_POP_STATS_EN only)
//
// Optional feature macro: LIFO_POP_STATS_EN
module lifo_pop_streamer #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Len_Width  = 8,
  parameter int unsigned Read_Gap   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Drain_Start,
  input  logic [Len_Width-1:0]  Drain_Len,
  input  logic                  LIFO_Empty,
  input  logic [Data_Width-1:0] LIFO_Data,
  output logic                  Read,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [Data_Width-1:0] Out_Data,
  output logic                  Out_Last,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Drain_Short
`ifdef LIFO_POP_STATS_EN
  ,
  output logic [15:0]           Pop_Total
`endif
);

  localparam int unsigned GapW = 3;
  localparam logic [GapW-1:0]      GAP_INIT = GapW'(Read_Gap - 1);
  localparam logic [Len_Width-1:0] CNT_MAX  = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_POP    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [Len_Width-1:0]  len_q, len_d;
  logic [Len_Width-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  short_q, short_d;
  logic                  read_q, read_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dshort_q, dshort_d;
  logic                  valid_q, valid_d;
  logic [Data_Width-1:0] buf_data_q [2];
  logic [Data_Width-1:0] buf_data_d [2];
  logic                  buf_last_q [2];
  logic                  buf_last_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  logic push, push_last, pop, inflight, len_hit;

  // Next-state, pop sequencing and output-buffer bookkeeping
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    short_d    = short_q;
    read_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dshort_d   = 1'b0;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    push       = 1'b0;
    push_last  = 1'b0;
    pop        = valid_q && Out_Ready;
    // A popped word is in flight from the Read cycle until it is captured
    inflight   = (state_q == S_POP) || ((state_q == S_GAP) && (gap_q == GAP_INIT));
    len_hit    = (len_q != '0) && (cnt_q == len_q);

    case (state_q)
      S_IDLE: begin
        if (Drain_Start) begin
          len_d   = Drain_Len;
          cnt_d   = '0;
          short_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (LIFO_Empty) begin
          short_d = (len_q != '0);
          state_d = S_FINISH;
        end else if ((occ_q + {1'b0, inflight}) < 2'd2) begin
          read_d  = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        gap_d   = GAP_INIT;
        state_d = S_GAP;
      end
      S_GAP: begin
        // LIFO Data_out is valid one cycle after the Read pulse
        if (gap_q == GAP_INIT) begin
          push      = 1'b1;
          push_last = len_hit;
        end
        if (gap_q == '0) begin
          state_d = len_hit ? S_FINISH : S_CHECK;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_FINISH: begin
        if (occ_q == 2'd0) begin
          done_d   = 1'b1;
          dshort_d = short_q;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      buf_data_d[wr_ptr_q] = LIFO_Data;
      buf_last_d[wr_ptr_q] = push_last;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    valid_d = (occ_d != 2'd0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      short_q    <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dshort_q   <= 1'b0;
      valid_q    <= 1'b0;
      buf_data_q <= '{default: '0};
      buf_last_q <= '{default: 1'b0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      short_q    <= short_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dshort_q   <= dshort_d;
      valid_q    <= valid_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign Read        = read_q;
  assign Out_Valid   = valid_q;
  assign Out_Data    = buf_data_q[rd_ptr_q];
  assign Out_Last    = valid_q & buf_last_q[rd_ptr_q];
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Drain_Short = dshort_q;

`ifdef LIFO_POP_STATS_EN
  logic [15:0] pop_total_q;

  // Saturating count of Read pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_total_q <= 16'h0000;
    end else if (read_q && (pop_total_q != 16'hFFFF)) begin
      pop_total_q <= pop_total_q + 16'd1;
    end
  end

  assign Pop_Total = pop_total_q;
`endif

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Directed testbench for lifo_pop_streamer with a behavioural LIFO model.
module tb_lifo_pop_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       Drain_Start;
  logic [7:0] Drain_Len;
  logic       LIFO_Empty;
  logic [7:0] LIFO_Data;
  logic       Read;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [7:0] Out_Data;
  logic       Out_Last;
  logic       Busy;
  logic       Done;
  logic       Drain_Short;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lifo_pop_streamer #(.Data_Width(8), .Len_Width(8), .Read_Gap(2)) dut (
    .clk(clk), .reset(reset), .Drain_Start(Drain_Start), .Drain_Len(Drain_Len),
    .LIFO_Empty(LIFO_Empty), .LIFO_Data(LIFO_Data), .Read(Read),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Out_Last(Out_Last), .Busy(Busy), .Done(Done), .Drain_Short(Drain_Short)
  );

  // LIFO model: registered Data_out, pointer decrements once per Read
  logic [7:0] stk [8];
  logic [7:0] load_vals [8];
  logic [3:0] sp = 4'd0;
  logic [3:0] load_n;
  logic       load_en;

  always @(posedge clk) begin
    if (load_en) begin
      stk <= load_vals;
      sp  <= load_n;
    end else if (Read && (sp != 4'd0)) begin
      LIFO_Data <= stk[3'(sp - 4'd1)];
      sp        <= sp - 4'd1;
    end
  end
  assign LIFO_Empty = (sp == 4'd0);

  // Stream monitor, sampled on the falling edge
  int cyc = 0, read_cnt = 0, consec_err = 0, empty_read_err = 0, hold_err = 0;
  int min_low = 1000, last_read_cyc = -1000, valid_cnt = 0, out_n = 0;
  logic [7:0] out_data_log [64];
  logic       out_last_log [64];
  logic       read_prev = 1'b0, valid_prev = 1'b0, ready_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      if (Read) begin
        read_cnt <= read_cnt + 1;
        if (read_prev) consec_err <= consec_err + 1;
        if (LIFO_Empty) empty_read_err <= empty_read_err + 1;
        if ((cyc - last_read_cyc - 1) < min_low) min_low <= cyc - last_read_cyc - 1;
        last_read_cyc <= cyc;
      end
      if (Out_Valid) valid_cnt <= valid_cnt + 1;
      if (valid_prev && !ready_prev && (!Out_Valid || (Out_Data !== data_prev)))
        hold_err <= hold_err + 1;
      if (Out_Valid && Out_Ready && (out_n < 64)) begin
        out_data_log[6'(out_n)] <= Out_Data;
        out_last_log[6'(out_n)] <= Out_Last;
        out_n <= out_n + 1;
      end
    end
    read_prev  <= Read;
    valid_prev <= Out_Valid && reset;
    ready_prev <= Out_Ready;
    data_prev  <= Out_Data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stack(input int n, input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
    load_vals = '{default: 8'h00};
    load_vals[0] = v0;
    load_vals[1] = v1;
    load_vals[2] = v2;
    load_vals[3] = v3;
    load_n  = 4'(n);
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic start_drain(input logic [7:0] len);
    Drain_Len   = len;
    Drain_Start = 1'b1;
    step();
    Drain_Start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok, output logic sh);
    ok = 1'b0;
    sh = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (Done) begin
        ok = 1'b1;
        sh = Drain_Short;
        break;
      end
    end
    step();
  endtask

  task automatic wait_read(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (Read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    total++; if (Read !== 1'b0) begin $display("FAIL reset_read: got %b want 0", Read); bad++; end
    total++; if (Out_Valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", Out_Valid); bad++; end
    total++; if (Busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", Busy); bad++; end
    total++; if ({Done, Drain_Short, Out_Last} !== 3'b000)
      begin $display("FAIL reset_flags: got %b want 000", {Done, Drain_Short, Out_Last}); bad++; end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_len2();
    bit ok; logic sh; int rb, nb, cb;
    load_stack(3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    rb = read_cnt; nb = out_n; cb = consec_err;
    start_drain(8'd2);
    wait_done(100, ok, sh);
    total++; if (ok !== 1'b1) begin $display("FAIL len2_done: got %b want 1", ok); bad++; end
    total++; if (sh !== 1'b0) begin $display("FAIL len2_short: got %b want 0", sh); bad++; end
    total++; if (read_cnt - rb != 2) begin $display("FAIL len2_reads: got %0d want 2", read_cnt - rb); bad++; end
    total++; if (out_n - nb != 2) begin $display("FAIL len2_words: got %0d want 2", out_n - nb); bad++; end
    total++; if (out_data_log[6'(nb)] !== 8'hC3)
      begin $display("FAIL len2_w0: got %h want c3", out_data_log[6'(nb)]); bad++; end
    total++; if (out_data_log[6'(nb + 1)] !== 8'hB2)
      begin $display("FAIL len2_w1: got %h want b2", out_data_log[6'(nb + 1)]); bad++; end
    total++; if ({out_last_log[6'(nb)], out_last_log[6'(nb + 1)]} !== 2'b01)
      begin $display("FAIL len2_last: got %b want 01", {out_last_log[6'(nb)], out_last_log[6'(nb + 1)]}); bad++; end
    total++; if (consec_err != cb) begin $display("FAIL len2_consec: got %0d want %0d", consec_err, cb); bad++; end
    total++; if (Busy !== 1'b0) begin $display("FAIL len2_busy: got %b want 0", Busy); bad++; end
  endtask

  task automatic test_until_empty();
    bit ok, rok; logic sh; int rb, nb, eb;
    load_stack(3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    rb = read_cnt; nb = out_n; eb = empty_read_err;
    start_drain(8'd0);
    wait_read(20, rok);
    total++; if (rok !== 1'b1) begin $display("FAIL empty_first_read: got %b want 1", rok); bad++; end
    // A second request mid-drain must be ignored
    step();
    Drain_Len = 8'd1; Drain_Start = 1'b1;
    step();
    Drain_Start = 1'b0;
    wait_done(100, ok, sh);
    total++; if (ok !== 1'b1) begin $display("FAIL empty_done: got %b want 1", ok); bad++; end
    total++; if (sh !== 1'b0) begin $display("FAIL empty_short: got %b want 0", sh); bad++; end
    total++; if (read_cnt - rb != 3) begin $display("FAIL empty_reads: got %0d want 3", read_cnt - rb); bad++; end
    total++; if (out_n - nb != 3) begin $display("FAIL empty_words: got %0d want 3", out_n - nb); bad++; end
    total++; if ({out_data_log[6'(nb)], out_data_log[6'(nb + 1)], out_data_log[6'(nb + 2)]} !== 24'hC3B2A1)
      begin $display("FAIL empty_data: got %h%h%h want c3b2a1", out_data_log[6'(nb)],
                     out_data_log[6'(nb + 1)], out_data_log[6'(nb + 2)]); bad++; end
    total++; if ({out_last_log[6'(nb)], out_last_log[6'(nb + 1)], out_last_log[6'(nb + 2)]} !== 3'b000)
      begin $display("FAIL empty_last: got %b want 000", {out_last_log[6'(nb)], out_last_log[6'(nb + 1)],
                     out_last_log[6'(nb + 2)]}); bad++; end
    total++; if (empty_read_err != eb) begin $display("FAIL empty_read_on_empty: got %0d want %0d", empty_read_err, eb); bad++; end
  endtask

  task automatic test_short();
    bit ok; logic sh; int rb, nb;
    load_stack(2, 8'h11, 8'h22, 8'h00, 8'h00);
    rb = read_cnt; nb = out_n;
    start_drain(8'd5);
    wait_done(100, ok, sh);
    total++; if (ok !== 1'b1) begin $display("FAIL short_done: got %b want 1", ok); bad++; end
    total++; if (sh !== 1'b1) begin $display("FAIL short_flag: got %b want 1", sh); bad++; end
    total++; if (read_cnt - rb != 2) begin $display("FAIL short_reads: got %0d want 2", read_cnt - rb); bad++; end
    total++; if (out_n - nb != 2) begin $display("FAIL short_words: got %0d want 2", out_n - nb); bad++; end
    total++; if ({out_data_log[6'(nb)], out_data_log[6'(nb + 1)]} !== 16'h2211)
      begin $display("FAIL short_data: got %h%h want 2211", out_data_log[6'(nb)], out_data_log[6'(nb + 1)]); bad++; end
    total++; if ({out_last_log[6'(nb)], out_last_log[6'(nb + 1)]} !== 2'b00)
      begin $display("FAIL short_last: got %b want 00", {out_last_log[6'(nb)], out_last_log[6'(nb + 1)]}); bad++; end
  endtask

  task automatic test_backpressure();
    bit ok; logic sh; int rb, nb, hb;
    load_stack(4, 8'h10, 8'h20, 8'h30, 8'h40);
    rb = read_cnt; nb = out_n; hb = hold_err;
    Out_Ready = 1'b0;
    start_drain(8'd4);
    repeat (30) step();
    @(negedge clk);
    total++; if (read_cnt - rb != 2) begin $display("FAIL bp_stall_reads: got %0d want 2", read_cnt - rb); bad++; end
    total++; if (Out_Valid !== 1'b1) begin $display("FAIL bp_valid: got %b want 1", Out_Valid); bad++; end
    total++; if (Out_Data !== 8'h40) begin $display("FAIL bp_head: got %h want 40", Out_Data); bad++; end
    total++; if (Busy !== 1'b1) begin $display("FAIL bp_busy: got %b want 1", Busy); bad++; end
    total++; if (out_n != nb) begin $display("FAIL bp_no_accept: got %0d want %0d", out_n, nb); bad++; end
    step();
    Out_Ready = 1'b1;
    wait_done(100, ok, sh);
    total++; if (ok !== 1'b1) begin $display("FAIL bp_done: got %b want 1", ok); bad++; end
    total++; if (sh !== 1'b0) begin $display("FAIL bp_short: got %b want 0", sh); bad++; end
    total++; if (read_cnt - rb != 4) begin $display("FAIL bp_reads: got %0d want 4", read_cnt - rb); bad++; end
    total++; if (out_n - nb != 4) begin $display("FAIL bp_words: got %0d want 4", out_n - nb); bad++; end
    total++; if ({out_data_log[6'(nb)], out_data_log[6'(nb + 1)], out_data_log[6'(nb + 2)], out_data_log[6'(nb + 3)]} !== 32'h40302010)
      begin $display("FAIL bp_data: got %h%h%h%h want 40302010", out_data_log[6'(nb)], out_data_log[6'(nb + 1)],
                     out_data_log[6'(nb + 2)], out_data_log[6'(nb + 3)]); bad++; end
    total++; if ({out_last_log[6'(nb)], out_last_log[6'(nb + 1)], out_last_log[6'(nb + 2)], out_last_log[6'(nb + 3)]} !== 4'b0001)
      begin $display("FAIL bp_last: got %b want 0001", {out_last_log[6'(nb)], out_last_log[6'(nb + 1)],
                     out_last_log[6'(nb + 2)], out_last_log[6'(nb + 3)]}); bad++; end
    total++; if (hold_err != hb) begin $display("FAIL bp_hold: got %0d want %0d", hold_err, hb); bad++; end
  endtask

  task automatic test_empty_start();
    bit ok; logic sh; int rb, vb;
    load_stack(0, 8'h00, 8'h00, 8'h00, 8'h00);
    rb = read_cnt; vb = valid_cnt;
    start_drain(8'd1);
    wait_done(3, ok, sh);
    total++; if (ok !== 1'b1) begin $display("FAIL estart_done: got %b want 1", ok); bad++; end
    total++; if (sh !== 1'b1) begin $display("FAIL estart_short: got %b want 1", sh); bad++; end
    total++; if (read_cnt != rb) begin $display("FAIL estart_reads: got %0d want 0", read_cnt - rb); bad++; end
    total++; if (valid_cnt != vb) begin $display("FAIL estart_valid: got %0d want 0", valid_cnt - vb); bad++; end
  endtask

  task automatic test_reset_mid_drain();
    bit ok, rok; logic sh; int rb, nb;
    load_stack(3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    start_drain(8'd0);
    wait_read(20, rok);
    total++; if (rok !== 1'b1) begin $display("FAIL mid_first_read: got %b want 1", rok); bad++; end
    step();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if ({Out_Valid, Busy, Read} !== 3'b000)
      begin $display("FAIL mid_reset_outs: got %b want 000", {Out_Valid, Busy, Read}); bad++; end
    step();
    reset = 1'b1;
    step();
    rb = read_cnt; nb = out_n;
    start_drain(8'd0);
    wait_done(100, ok, sh);
    total++; if (ok !== 1'b1) begin $display("FAIL mid_done: got %b want 1", ok); bad++; end
    total++; if (read_cnt - rb != 2) begin $display("FAIL mid_reads: got %0d want 2", read_cnt - rb); bad++; end
    total++; if (out_n - nb != 2) begin $display("FAIL mid_words: got %0d want 2", out_n - nb); bad++; end
    total++; if ({out_data_log[6'(nb)], out_data_log[6'(nb + 1)]} !== 16'hB2A1)
      begin $display("FAIL mid_data: got %h%h want b2a1", out_data_log[6'(nb)], out_data_log[6'(nb + 1)]); bad++; end
  endtask

  task automatic test_read_spacing();
    total++; if (min_low < 2) begin $display("FAIL spacing_min_low: got %0d want >=2", min_low); bad++; end
    total++; if (consec_err != 0) begin $display("FAIL spacing_consec: got %0d want 0", consec_err); bad++; end
    total++; if (empty_read_err != 0) begin $display("FAIL spacing_empty_read: got %0d want 0", empty_read_err); bad++; end
  endtask

  initial begin
    reset       = 1'b0;
    Drain_Start = 1'b0;
    Drain_Len   = 8'd0;
    Out_Ready   = 1'b1;
    load_en     = 1'b0;
    load_n      = 4'd0;
    load_vals   = '{default: 8'h00};
    test_reset();
    test_len2();
    test_until_empty();
    test_short();
    test_backpressure();
    test_empty_start();
    test_reset_mid_drain();
    test_read_spacing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
